// File: rtl/seq_dect_checker.sv
// seq_dect_checker: reference model of the overlapping Mealy "010" detector
// that flags output disagreements and keeps detection/error/cycle statistics.
module seq_dect_checker #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_seq,
  input  logic             i_out,
  output logic             o_exp_out,
  output logic             o_mismatch,
  output logic             o_err_flag,
  output logic [CNT_W-1:0] o_det_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_first_err_cycle
);
  typedef enum logic [1:0] {S_IDLE, S_0, S_01} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t           r_state, w_next;
  logic             r_mismatch, r_err_flag, w_miss;
  logic [CNT_W-1:0] r_det_cnt, r_err_cnt, r_cycle_cnt, r_first_err_cycle;
  // A 0 always leaves a fresh "0" prefix, which is what makes detection overlap.
  always_comb begin
    w_next = i_seq ? (r_state == S_0 ? S_01 : S_IDLE) : S_0;
  end
  assign o_exp_out = i_rst && (r_state == S_01) && !i_seq;
  // Case inequality so an X/Z detector output is reported, not masked.
  assign w_miss = i_out !== o_exp_out;
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state           <= S_IDLE;
      r_mismatch        <= 1'b0;
      r_err_flag        <= 1'b0;
      r_det_cnt         <= '0;
      r_err_cnt         <= '0;
      r_cycle_cnt       <= '0;
      r_first_err_cycle <= '0;
    end else begin
      r_state    <= w_next;
      r_mismatch <= w_miss;
      if (r_cycle_cnt != MAX) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (o_exp_out && r_det_cnt != MAX) r_det_cnt <= r_det_cnt + CNT_W'(1);
      if (w_miss && r_err_cnt != MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (w_miss && !r_err_flag) begin
        r_first_err_cycle <= r_cycle_cnt;
        r_err_flag        <= 1'b1;
      end
    end
  end
  assign o_mismatch        = r_mismatch;
  assign o_err_flag        = r_err_flag;
  assign o_det_cnt         = r_det_cnt;
  assign o_err_cnt         = r_err_cnt;
  assign o_cycle_cnt       = r_cycle_cnt;
  assign o_first_err_cycle = r_first_err_cycle;
endmodule
